co_k_rom_reader: RTL and testbench

CO_K_ROM_READER -- requirements
Module: co_k_rom_reader

---
 rtl/co_k_rom_reader.sv | 212 +++++++++++++++++++++
 tb/tb_co_k_rom_reader.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/co_k_rom_reader.sv
// co_k_rom_reader
// Reads a burst of coefficient words from a synchronous ROM (one-cycle read
// latency) and presents them as a valid/ready stream.
//
// Ports:
//   clk, rst        single clock, asynchronous active-high reset
//   start_i         one-cycle burst request (ignored while busy)
//   base_addr_i     first ROM address of the burst, sampled with start_i
//   len_i           number of words in the burst (0..2^ADDR_W), sampled with start_i
//   rom_en_o        ROM read enable
//   rom_addr_o      ROM read address, holds the last issued address when idle
//   rom_data_i      ROM read data, valid the cycle after rom_en_o=1
//   coef_o          stream data
//   coef_val_o      stream valid
//   coef_rdy_i      stream ready
//   coef_last_o     marks the final word of the burst (qualified by coef_val_o)
//   busy_o          high from the accepted start until burst completion
//   done_o          one-cycle pulse on burst completion (also for len_i=0)
//   dbg_state_o     current FSM state (0 IDLE, 1 RUN, 2 DRAIN)
//
// Stream handshake: a word transfers on every rising clk edge where
// coef_val_o=1 and coef_rdy_i=1; once coef_val_o is raised, coef_o and
// coef_last_o hold steady and coef_val_o stays high until that transfer.
//
// Buffering: the stream output register is followed by a 2-entry FIFO.
// Incoming ROM data goes straight into the output register when that register
// is free and the FIFO is empty, otherwise it is queued. A read is issued only
// when FIFO occupancy plus reads in flight is below 2, so the FIFO can never
// overflow, yet a continuous one-word-per-cycle flow is still possible.

module co_k_rom_reader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W:0]   len_i,
    output logic              rom_en_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_data_i,
    output logic [DATA_W-1:0] coef_o,
    output logic              coef_val_o,
    input  logic              coef_rdy_i,
    output logic              coef_last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    logic [ADDR_W-1:0] r_next_addr;      // address of the next read to schedule
    logic [ADDR_W:0]   r_issue_left;     // reads not yet scheduled
    logic              r_rom_en;
    logic [ADDR_W-1:0] r_rom_addr;
    logic              r_rom_last;       // the read issued this cycle is the final one
    logic              r_inflight;       // rom_data_i carries a word this cycle
    logic              r_inflight_last;
    logic [DATA_W-1:0] r_fifo_data [0:1];
    logic [1:0]        r_fifo_last;
    logic [1:0]        r_cnt;            // FIFO occupancy, 0..2
    logic [DATA_W-1:0] r_coef;
    logic              r_val;
    logic              r_last;
    logic              r_busy;
    logic              r_done;

    logic              w_pop;
    logic              w_refill;
    logic              w_take_fifo;
    logic              w_take_in;
    logic              w_push;
    logic              w_wr_idx;
    logic [1:0]        w_cnt_nxt;
    logic              w_start_ok;
    logic [ADDR_W:0]   w_left_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic              w_run_nxt;
    logic              w_sched;
    logic              w_last_xfer;

    always_comb begin
        w_pop       = r_val & coef_rdy_i;
        // The output register can accept a word if empty or emptying now.
        w_refill    = ~r_val | w_pop;
        w_take_fifo = w_refill & (r_cnt != 2'd0);
        w_take_in   = w_refill & (r_cnt == 2'd0) & r_inflight;
        w_push      = r_inflight & ~w_take_in;
        // Slot for the incoming word after any shift caused by a FIFO pop.
        w_wr_idx    = w_take_fifo ? (r_cnt == 2'd2) : (r_cnt == 2'd1);
        w_cnt_nxt   = r_cnt - {1'b0, w_take_fifo} + {1'b0, w_push};

        w_start_ok  = (r_state == S_IDLE) & start_i & (len_i != '0);
        w_left_nxt  = w_start_ok ? len_i : r_issue_left;
        w_addr_nxt  = w_start_ok ? base_addr_i : r_next_addr;
        w_run_nxt   = w_start_ok | ((r_state == S_RUN) & ~(r_rom_en & r_rom_last));
        // Decide next cycle's read from next cycle's occupancy; the read issued
        // this cycle (r_rom_en) is the one that will be in flight then.
        w_sched     = w_run_nxt & (w_left_nxt != '0) &
                      (({1'b0, w_cnt_nxt} + {2'b00, r_rom_en}) < 3'd2);
        w_last_xfer = w_pop & r_last;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_next_addr     <= '0;
            r_issue_left    <= '0;
            r_rom_en        <= 1'b0;
            r_rom_addr      <= '0;
            r_rom_last      <= 1'b0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_fifo_data[0]  <= '0;
            r_fifo_data[1]  <= '0;
            r_fifo_last     <= '0;
            r_cnt           <= '0;
            r_coef          <= '0;
            r_val           <= 1'b0;
            r_last          <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        if (len_i != '0) begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                        end else begin
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (r_rom_en && r_rom_last) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_last_xfer) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            // Read issue: address only moves when a read is issued.
            r_rom_en <= w_sched;
            if (w_sched) begin
                r_rom_addr   <= w_addr_nxt;
                r_rom_last   <= (w_left_nxt == LEN_ONE);
                r_next_addr  <= w_addr_nxt + ADDR_ONE;
                r_issue_left <= w_left_nxt - LEN_ONE;
            end
            r_inflight      <= r_rom_en;
            r_inflight_last <= r_rom_en & r_rom_last;

            // Output register refill, FIFO head first to keep order.
            if (w_take_fifo) begin
                r_coef <= r_fifo_data[0];
                r_last <= r_fifo_last[0];
                r_val  <= 1'b1;
            end else if (w_take_in) begin
                r_coef <= rom_data_i;
                r_last <= r_inflight_last;
                r_val  <= 1'b1;
            end else if (w_pop) begin
                r_val  <= 1'b0;
                r_last <= 1'b0;
            end

            // FIFO shift on pop; a same-cycle push to slot 0 overrides the shift.
            if (w_take_fifo) begin
                r_fifo_data[0] <= r_fifo_data[1];
                r_fifo_last[0] <= r_fifo_last[1];
            end
            if (w_push) begin
                r_fifo_data[w_wr_idx] <= rom_data_i;
                r_fifo_last[w_wr_idx] <= r_inflight_last;
            end
            r_cnt <= w_cnt_nxt;
        end
    end

    assign rom_en_o    = r_rom_en;
    assign rom_addr_o  = r_rom_addr;
    assign coef_o      = r_coef;
    assign coef_val_o  = r_val;
    assign coef_last_o = r_last;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_co_k_rom_reader.sv
// Testbench for co_k_rom_reader: table of bursts plus a hand-written
// mid-burst reset sequence. A ROM model answers reads one cycle later; the
// expected address and data/last streams are queued when a burst is started
// and compared as the DUT issues reads and transfers words.

module tb_co_k_rom_reader;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 20;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_i;
  logic [ADDR_W-1:0] base_addr_i;
  logic [ADDR_W:0]   len_i;
  logic              rom_en_o;
  logic [ADDR_W-1:0] rom_addr_o;
  logic [DATA_W-1:0] rom_data_i;
  logic [DATA_W-1:0] coef_o;
  logic              coef_val_o;
  logic              coef_rdy_i;
  logic              coef_last_o;
  logic              busy_o;
  logic              done_o;
  logic [1:0]        dbg_state_o;

  co_k_rom_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .len_i       (len_i),
    .rom_en_o    (rom_en_o),
    .rom_addr_o  (rom_addr_o),
    .rom_data_i  (rom_data_i),
    .coef_o      (coef_o),
    .coef_val_o  (coef_val_o),
    .coef_rdy_i  (coef_rdy_i),
    .coef_last_o (coef_last_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .dbg_state_o (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- ROM model ----------------
  function automatic logic [DATA_W-1:0] rom_f(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] x;
    x = DATA_W'(a) * 20'd977;
    return x ^ 20'h5A3C1;
  endfunction

  // Data only valid the cycle after a read; junk otherwise.
  always @(posedge clk) begin
    if (rom_en_o) rom_data_i <= rom_f(rom_addr_o);
    else          rom_data_i <= DATA_W'($urandom);
  end

  // ---------------- scoreboard ----------------
  logic [DATA_W:0]   exp_q[$];   // {last, data}
  logic [ADDR_W-1:0] addr_q[$];
  int n_vec = 0;
  int n_fail = 0;
  int burst_words = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int first_val_cyc = 0;
  int issued = 0;
  int xferred = 0;
  int start_cyc = 0;
  int rdy_mode = 2;
  logic            prev_stall = 1'b0;
  logic [DATA_W:0] prev_out;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall)
        check("stall_hold", {coef_val_o, coef_last_o, coef_o}, {1'b1, prev_out});
      if (rom_en_o) begin
        // Live words (output reg + FIFO + in flight) may not exceed 3.
        check("issue_slot", 32'((issued - xferred) <= 2), 32'd1);
        check("en_while_busy", busy_o, 1'b1);
        if (addr_q.size() == 0) fail_now("unexpected_read");
        else check("rom_addr", rom_addr_o, addr_q.pop_front());
        issued++;
      end
      if (coef_val_o && coef_rdy_i) begin
        if (burst_words == 0) first_val_cyc = cyc;
        if (exp_q.size() == 0) fail_now("unexpected_word");
        else check("coef", {coef_last_o, coef_o}, exp_q.pop_front());
        burst_words++;
        xferred++;
      end
      prev_stall = coef_val_o && !coef_rdy_i;
      prev_out   = {coef_last_o, coef_o};
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // ---------------- ready driver ----------------
  // mode 0/2: always ready; mode 1: random with a 10-cycle stall window.
  initial begin
    coef_rdy_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 1) begin
        if ((cyc - start_cyc) >= 6 && (cyc - start_cyc) < 16) coef_rdy_i = 1'b0;
        else coef_rdy_i = 1'($urandom_range(0, 1));
      end else begin
        coef_rdy_i = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic queue_burst(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] len);
    logic [ADDR_W-1:0] a;
    a = base;
    for (int i = 0; i < int'(len); i++) begin
      addr_q.push_back(a);
      exp_q.push_back({1'(i == int'(len) - 1), rom_f(a)});
      a++;
    end
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] len);
    @(posedge clk);
    #2;
    start_i     = 1'b1;
    base_addr_i = base;
    len_i       = len;
    start_cyc   = cyc;
    @(posedge clk);
    #2;
    start_i = 1'b0;
  endtask

  task automatic run_burst(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] len,
                           input int mode, input bit inject);
    int d0;
    int budget;
    int sc;
    queue_burst(base, len);
    burst_words = 0;
    d0 = done_cnt;
    rdy_mode = mode;
    pulse_start(base, len);
    sc = start_cyc;
    check("busy_rise", busy_o, 1'(len != 0));
    if (len == 0) check("zero_len_done", done_o, 1'b1);
    if (inject) begin
      // Unqueued request while busy: any effect shows up as a queue miscompare.
      @(posedge clk);
      #2;
      start_i = 1'b1;
      base_addr_i = 10'h300;
      len_i = 11'd5;
      @(posedge clk);
      #2;
      start_i = 1'b0;
    end
    budget = int'(len) * 10 + 60;
    for (int k = 0; k < budget && done_cnt == d0; k++) @(posedge clk);
    if (done_cnt == d0) fail_now("done_timeout");
    repeat (3) @(posedge clk);
    #2;
    check("word_count", burst_words, int'(len));
    check("exp_q_empty", exp_q.size(), 0);
    check("addr_q_empty", addr_q.size(), 0);
    check("done_pulses", done_cnt - d0, 1);
    check("busy_fall", busy_o, 1'b0);
    if (len == 0) begin
      check("zero_done_cyc", done_cyc - sc, 1);
    end else if (mode == 0) begin
      check("first_val_lat", first_val_cyc - sc, 3);
      check("done_cyc", done_cyc - sc, 3 + int'(len));
    end
    rdy_mode = 2;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [ADDR_W-1:0] base;
    logic [ADDR_W:0]   len;
    int                mode;
    bit                inject;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int d0;
    int k;
    vecs[0] = '{10'h010, 11'd4,    0, 1'b0};
    vecs[1] = '{10'h3FE, 11'd4,    0, 1'b0};
    vecs[2] = '{10'h055, 11'd8,    1, 1'b0};
    vecs[3] = '{10'h000, 11'd1,    0, 1'b0};
    vecs[4] = '{10'h123, 11'd0,    0, 1'b0};
    vecs[5] = '{10'h080, 11'd6,    0, 1'b1};
    vecs[6] = '{10'h3F0, 11'd20,   1, 1'b0};
    vecs[7] = '{10'h200, 11'd1024, 0, 1'b0};

    rst = 1'b1;
    start_i = 1'b0;
    base_addr_i = '0;
    len_i = '0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_ctrl", {rom_en_o, coef_val_o, coef_last_o, busy_o, done_o}, 5'b0);
    check("reset_state", dbg_state_o, 2'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      run_burst(vecs[i].base, vecs[i].len, vecs[i].mode, vecs[i].inject);

    // Mid-burst reset after 3 of 16 words.
    queue_burst(10'h040, 11'd16);
    burst_words = 0;
    rdy_mode = 0;
    pulse_start(10'h040, 11'd16);
    k = 0;
    while (burst_words < 3 && k < 100) begin
      @(posedge clk);
      #2;
      k++;
    end
    if (burst_words < 3) fail_now("rst_seq_timeout");
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    check("rst_async_ctrl", {rom_en_o, coef_val_o, coef_last_o, busy_o, done_o}, 5'b0);
    check("rst_async_addr", rom_addr_o, 10'h000);
    check("rst_async_coef", coef_o, 20'h0);
    exp_q.delete();
    addr_q.delete();
    issued = 0;
    xferred = 0;
    prev_stall = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_no_done", done_cnt - d0, 0);
    run_burst(10'h100, 11'd2, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
